// File: rtl/mem_block_mover_if.sv
// Command port plus RAM pin bundle between the Forth core, the block mover and the RAM mux.
// master = the mover; slave = the core/RAM side it faces.
interface mem_block_mover_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_fill;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] Address;
    logic              R_F;
    logic [DATA_W-1:0] Data_In;
    logic [DATA_W-1:0] Data_Out;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, Data_Out,
        output cmd_ready, busy, done, Address, R_F, Data_In
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, Data_Out,
        input  cmd_ready, busy, done, Address, R_F, Data_In
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block COPY / FILL engine that owns the single-port RAM while busy.
// Copy is one read cycle then one write cycle per word; fill writes one word per cycle.
module mem_block_mover #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_block_mover_if.master  bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rf_q, rf_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign bus.cmd_ready = (state_q == IDLE) && rst_n;
    assign bus.Address   = addr_q;
    assign bus.R_F       = rf_q;
    assign bus.Data_In   = din_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // State and registered outputs; reset drops R_F at once so an aborted command writes nothing more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            rf_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            rf_q    <= rf_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        rf_d    = rf_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                rf_d = 1'b0;
                if (bus.cmd_valid) begin
                    src_d = bus.cmd_src;
                    dst_d = bus.cmd_dst;
                    rem_d = bus.cmd_len;
                    if (bus.cmd_len == LEN_W'(0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (bus.cmd_op) begin
                        state_d = FILL;
                        addr_d  = bus.cmd_dst;
                        rf_d    = 1'b1;
                        din_d   = bus.cmd_fill;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = RD;
                        addr_d  = bus.cmd_src;
                        busy_d  = 1'b1;
                    end
                end
            end
            RD: begin
                // Data_In doubles as the hold register for the word just read.
                state_d = WR;
                addr_d  = dst_q;
                rf_d    = 1'b1;
                din_d   = bus.Data_Out;
            end
            WR: begin
                rem_d = rem_q - LEN_W'(1);
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                rf_d  = 1'b0;
                if (rem_q > LEN_W'(1)) begin
                    state_d = RD;
                    addr_d  = src_q + ADDR_W'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            FILL: begin
                rem_d = rem_q - LEN_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                if (rem_q > LEN_W'(1)) begin
                    addr_d = dst_q + ADDR_W'(1);
                end else begin
                    state_d = DONE;
                    rf_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                rf_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rf_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural async-read RAM on the bus.
module tb_mem_block_mover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_block_mover_if #(.ADDR_W(12), .DATA_W(3)) bus ();

    mem_block_mover #(.ADDR_W(12), .DATA_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [2:0]  ram [4096];
    logic        tb_clr = 1'b0;
    logic        tb_we = 1'b0;
    logic [11:0] tb_addr = '0;
    logic [2:0]  tb_data = '0;

    // RAM model: the bench's preload port takes priority over the mover's write.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 4096; i++) ram[12'(i)] <= '0;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end else if (bus.R_F) begin
            ram[bus.Address] <= bus.Data_In;
        end
    end
    assign bus.Data_Out = ram[bus.Address];

    int n_checks = 0;
    int n_fail = 0;
    int rf_bad = 0;

    always @(negedge clk) begin
        if (rst_n && bus.R_F && !bus.busy) rf_bad++;
    end

    task automatic clear_ram();
        @(negedge clk);
        tb_clr = 1'b1;
        @(posedge clk);
        #1 tb_clr = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [2:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic drive_cmd(input logic op, input logic [11:0] src, input logic [11:0] dst,
                             input logic [12:0] len, input logic [2:0] fill);
        bus.cmd_op = op;
        bus.cmd_src = src;
        bus.cmd_dst = dst;
        bus.cmd_len = len;
        bus.cmd_fill = fill;
    endtask

    // Issue one command from IDLE and count cycles until done (bounded).
    task automatic run_cmd(input logic op, input logic [11:0] src, input logic [11:0] dst,
                           input logic [12:0] len, input logic [2:0] fill,
                           output int cyc, output int busy_cyc, output int rf_cyc);
        bit seen = 1'b0;
        @(negedge clk);
        drive_cmd(op, src, dst, len, fill);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        rf_cyc = 0;
        while (!seen && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cyc++;
            if (bus.R_F) rf_cyc++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles (required done)", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.R_F} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/busy/done/R_F=%b required 1000",
                     {bus.cmd_ready, bus.busy, bus.done, bus.R_F});
        end
        n_checks++;
        if (bus.Address !== 12'd0 || bus.Data_In !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_bus: Address=%0d Data_In=%0d required 0 0", bus.Address, bus.Data_In);
        end
    endtask

    task automatic test_fill();
        int cyc, bc, rc, bad;
        clear_ram();
        poke(12'd63, 3'd1);
        poke(12'd72, 3'd1);
        run_cmd(1'b1, 12'd0, 12'd64, 13'd8, 3'b101, cyc, bc, rc);
        n_checks++;
        if (bc !== 8 || cyc !== 9 || rc !== 8) begin
            n_fail++;
            $display("FAIL fill_latency: busy=%0d done_at=%0d rf=%0d required 8 9 8", bc, cyc, rc);
        end
        bad = 0;
        for (int i = 64; i < 72; i++) if (ram[12'(i)] !== 3'd5) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL fill_data: %0d words differ from 5 required 0", bad);
        end
        n_checks++;
        if (ram[12'd63] !== 3'd1 || ram[12'd72] !== 3'd1) begin
            n_fail++;
            $display("FAIL fill_bounds: ram63=%0d ram72=%0d required 1 1", ram[12'd63], ram[12'd72]);
        end
    endtask

    task automatic test_copy();
        int cyc, bc, rc, bad;
        logic [2:0] pat [8];
        pat = '{3'd0, 3'd7, 3'd7, 3'd4, 3'd7, 3'd0, 3'd0, 3'd3};
        clear_ram();
        for (int i = 0; i < 8; i++) poke(12'(64 + i), pat[3'(i)]);
        poke(12'd208, 3'd2);
        run_cmd(1'b0, 12'd64, 12'd200, 13'd8, 3'd0, cyc, bc, rc);
        n_checks++;
        if (bc !== 16 || cyc !== 17 || rc !== 8) begin
            n_fail++;
            $display("FAIL copy_latency: busy=%0d done_at=%0d rf=%0d required 16 17 8", bc, cyc, rc);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) if (ram[12'(200 + i)] !== pat[3'(i)]) bad++;
        n_checks++;
        if (bad !== 0 || ram[12'd208] !== 3'd2 || ram[12'd199] !== 3'd0) begin
            n_fail++;
            $display("FAIL copy_data: %0d bad words ram199=%0d ram208=%0d required 0 0 2",
                     bad, ram[12'd199], ram[12'd208]);
        end
    endtask

    task automatic test_wrap();
        int cyc, bc, rc;
        clear_ram();
        poke(12'd4094, 3'd1);
        poke(12'd4095, 3'd2);
        poke(12'd0, 3'd3);
        poke(12'd1, 3'd4);
        run_cmd(1'b0, 12'd4094, 12'd10, 13'd4, 3'd0, cyc, bc, rc);
        n_checks++;
        if ({ram[12'd10], ram[12'd11], ram[12'd12], ram[12'd13]} !== {3'd1, 3'd2, 3'd3, 3'd4}) begin
            n_fail++;
            $display("FAIL copy_wrap: ram10..13=%0d %0d %0d %0d required 1 2 3 4",
                     ram[12'd10], ram[12'd11], ram[12'd12], ram[12'd13]);
        end
        run_cmd(1'b1, 12'd0, 12'd4095, 13'd2, 3'd7, cyc, bc, rc);
        n_checks++;
        if ({ram[12'd4094], ram[12'd4095], ram[12'd0], ram[12'd1]} !== {3'd1, 3'd7, 3'd7, 3'd4}) begin
            n_fail++;
            $display("FAIL fill_wrap: ram4094,4095,0,1=%0d %0d %0d %0d required 1 7 7 4",
                     ram[12'd4094], ram[12'd4095], ram[12'd0], ram[12'd1]);
        end
    endtask

    task automatic test_len_bounds();
        int cyc, bc, rc, bad;
        clear_ram();
        run_cmd(1'b1, 12'd0, 12'd5, 13'd0, 3'd7, cyc, bc, rc);
        n_checks++;
        if (cyc !== 1 || bc !== 0 || rc !== 0 || ram[12'd5] !== 3'd0) begin
            n_fail++;
            $display("FAIL len_zero: done_at=%0d busy=%0d rf=%0d ram5=%0d required 1 0 0 0",
                     cyc, bc, rc, ram[12'd5]);
        end
        run_cmd(1'b1, 12'd0, 12'd123, 13'd4096, 3'd2, cyc, bc, rc);
        n_checks++;
        if (rc !== 4096 || bc !== 4096) begin
            n_fail++;
            $display("FAIL fill_full_count: rf=%0d busy=%0d required 4096 4096", rc, bc);
        end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[12'(i)] !== 3'd2) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL fill_full_data: %0d words differ from 2 required 0", bad);
        end
    endtask

    task automatic test_reset_abort();
        clear_ram();
        @(negedge clk);
        drive_cmd(1'b1, 12'd0, 12'd500, 13'd10, 3'd6);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.R_F !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: R_F=%b ready=%b busy=%b required 0 0 0",
                     bus.R_F, bus.cmd_ready, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: cmd_ready=%b required 1", bus.cmd_ready);
        end
        n_checks++;
        if ({ram[12'd500], ram[12'd501], ram[12'd502], ram[12'd503]} !== {3'd6, 3'd6, 3'd6, 3'd0}) begin
            n_fail++;
            $display("FAIL abort_data: ram500..503=%0d %0d %0d %0d required 6 6 6 0",
                     ram[12'd500], ram[12'd501], ram[12'd502], ram[12'd503]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, bc = 0, rdy = 0;
        bit seen = 1'b0;
        clear_ram();
        poke(12'd100, 3'd6);
        @(negedge clk);
        drive_cmd(1'b0, 12'd100, 12'd101, 13'd4, 3'd0);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 drive_cmd(1'b1, 12'd0, 12'd300, 13'd2, 3'd1);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bc++;
            if (bus.busy && bus.cmd_ready) rdy++;
            if (bus.done) seen = 1'b1;
        end
        n_checks++;
        if (!seen || bc !== 8 || rdy !== 0) begin
            n_fail++;
            $display("FAIL overlap_timing: done=%b busy=%0d ready_while_busy=%0d required 1 8 0",
                     seen, bc, rdy);
        end
        n_checks++;
        if ({ram[12'd101], ram[12'd102], ram[12'd103], ram[12'd104], ram[12'd105]}
            !== {3'd6, 3'd6, 3'd6, 3'd6, 3'd0}) begin
            n_fail++;
            $display("FAIL overlap_data: ram101..105=%0d %0d %0d %0d %0d required 6 6 6 6 0",
                     ram[12'd101], ram[12'd102], ram[12'd103], ram[12'd104], ram[12'd105]);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle: ready=%b busy=%b required 1 0", bus.cmd_ready, bus.busy);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_accept: busy=%b required 1", bus.busy);
        end
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        n_checks++;
        if (!seen || {ram[12'd299], ram[12'd300], ram[12'd301], ram[12'd302]} !== {3'd0, 3'd1, 3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL held_data: done=%b ram299..302=%0d %0d %0d %0d required 1 0 1 1 0",
                     seen, ram[12'd299], ram[12'd300], ram[12'd301], ram[12'd302]);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        drive_cmd(1'b0, 12'd0, 12'd0, 13'd0, 3'd0);
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_len_bounds();
        test_reset_abort();
        test_back_to_back();
        n_checks++;
        if (rf_bad !== 0) begin
            n_fail++;
            $display("FAIL rf_when_idle: %0d cycles with R_F=1 and busy=0 required 0", rf_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
